// File: rtl/message_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// message_receiver
//
// Receives the 6-bit message link. Each frame is one start bit (0), six data
// bits sent LSB first, and one stop bit (1). The receiver passes the serial
// line through a two-flop synchronizer. It confirms the start bit at its
// midpoint and then samples every following bit at its midpoint.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit. Must be even, range 4..1023.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   sin       : serial line, asynchronous to clk; idles high
//   msg_out   : last correctly framed message
//   valid     : one-cycle pulse when msg_out has been updated
//   frame_err : one-cycle pulse when the stop bit was sampled low
//   busy      : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module message_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic [5:0] msg_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [9:0] HALF_M1 = 10'(CLKS_PER_BIT / 2 - 1);
  localparam logic [9:0] FULL_M1 = 10'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t     state, next;
  logic       s1, sin_s;
  logic [9:0] cnt;
  logic [3:0] bitcnt;
  logic [5:0] data;

  logic cnt_clr, cnt_inc, bit_clr, bit_inc, shift, load, err;

  // Both flops reset high, so the line reads idle until real data arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      sin_s <= 1'b1;
    end else begin
      s1    <= sin;
      sin_s <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next    = state;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    bit_clr = 1'b0;
    bit_inc = 1'b0;
    shift   = 1'b0;
    load    = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!sin_s) next = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          // A start bit must still be low at its midpoint. Otherwise treat
          // it as a glitch and return to IDLE.
          cnt_clr = 1'b1;
          if (!sin_s) begin
            next    = DATA;
            bit_clr = 1'b1;
          end else begin
            next = IDLE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          shift   = 1'b1;
          bit_inc = 1'b1;
          if (bitcnt == 4'd5) next = STOP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          if (sin_s) begin
            load = 1'b1;
            next = IDLE;
          end else begin
            err  = 1'b1;
            next = BRK;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      BRK: begin
        // Stay here while the line is held low. A held break does not count
        // as a new start bit.
        cnt_clr = 1'b1;
        if (sin_s) next = IDLE;
      end
      default: begin
        next    = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bitcnt    <= '0;
      data      <= '0;
      msg_out   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 10'd1;

      if (bit_clr)      bitcnt <= '0;
      else if (bit_inc) bitcnt <= bitcnt + 4'd1;

      // Bits arrive LSB first and enter at the MSB end, so after six shifts
      // bit 0 is in data[0].
      if (shift) data <= {sin_s, data[5:1]};

      if (load) msg_out <= data;

      valid     <= load;
      frame_err <= err;
      busy      <= (next != IDLE);
    end
  end

endmodule

// File: tb/tb_message_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_message_receiver
//
// Directed testbench for message_receiver with CLKS_PER_BIT = 8. All stimulus
// changes 1 ns after a rising edge. A negedge monitor records output pulses
// together with the rising-edge count, so each event time can be compared
// with e0 of its frame.
// -----------------------------------------------------------------------------
module tb_message_receiver;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b1;
  logic [5:0] msg_out;
  logic       valid, frame_err, busy;

  message_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .msg_out   (msg_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Event monitor
  int n_valid = 0, n_err = 0, n_both = 0, n_rise = 0;
  int last_valid_cyc = -1, last_err_cyc = -1, last_fall_cyc = -1, last_rise_cyc = -1;
  logic [5:0] last_msg = '0;
  logic busy_prev = 1'b0;
  int vq_cyc[$];
  logic [5:0] vq_msg[$];

  always @(negedge clk) begin
    busy_prev <= busy;
    if (valid) begin
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
      last_msg       <= msg_out;
      vq_cyc.push_back(cyc);
      vq_msg.push_back(msg_out);
    end
    if (frame_err) begin
      n_err        <= n_err + 1;
      last_err_cyc <= cyc;
    end
    if (valid && frame_err) n_both <= n_both + 1;
    if (busy && !busy_prev) begin
      n_rise        <= n_rise + 1;
      last_rise_cyc <= cyc;
    end
    if (!busy && busy_prev) last_fall_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 ns after a rising edge. The next rising edge is e0 of the frame.
  task automatic send_frame(input logic [5:0] d, input logic stop_bit, output int t0);
    logic [7:0] bits;
    bits = {stop_bit, d, 1'b0};
    t0   = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      sin = bits[i];
      tick(CPB);
    end
  endtask

  int t0, ta, tb, base, nv, ne, nr;

  initial begin
    // Reset held with the line toggling
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sin = ~sin;
      tick(1);
    end
    check("rst_msg",   32'(msg_out),   32'h0);
    check("rst_valid", 32'(valid),     32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    sin = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(100);
    check("quiet_valid", 32'(n_valid), 32'd0);
    check("quiet_err",   32'(n_err),   32'd0);
    check("quiet_busy",  32'(n_rise),  32'd0);

    // Single frame 6'b101101
    nv = n_valid;
    ne = n_err;
    send_frame(6'h2D, 1'b1, t0);
    tick(4);
    check("single_count",  32'(n_valid),        32'(nv + 1));
    check("single_msg",    32'(last_msg),       32'h2D);
    check("single_vcyc",   32'(last_valid_cyc), 32'(t0 + 62));
    check("single_busyup", 32'(last_rise_cyc),  32'(t0 + 2));
    check("single_busydn", 32'(last_fall_cyc),  32'(t0 + 62));
    check("single_noerr",  32'(n_err),          32'(ne));
    check("single_out",    32'(msg_out),        32'h2D);

    // Back-to-back frames, one stop bit each
    base = vq_cyc.size();
    send_frame(6'h00, 1'b1, ta);
    send_frame(6'h3F, 1'b1, tb);
    tick(4);
    check("b2b_count", 32'(vq_cyc.size()), 32'(base + 2));
    if (vq_cyc.size() >= base + 2) begin
      check("b2b_msg0", 32'(vq_msg[base]),     32'h00);
      check("b2b_msg1", 32'(vq_msg[base + 1]), 32'h3F);
      check("b2b_cyc0", 32'(vq_cyc[base]),     32'(ta + 62));
      check("b2b_gap",  32'(vq_cyc[base + 1] - vq_cyc[base]), 32'd64);
    end

    // Two-cycle glitch: START aborts at the midpoint recheck
    nv = n_valid;
    ne = n_err;
    nr = n_rise;
    sin = 1'b0;
    tick(2);
    sin = 1'b1;
    tick(20);
    check("glitch_valid", 32'(n_valid), 32'(nv));
    check("glitch_err",   32'(n_err),   32'(ne));
    check("glitch_rise",  32'(n_rise),  32'(nr + 1));
    check("glitch_busy",  32'(busy),    32'h0);
    check("glitch_msg",   32'(msg_out), 32'h3F);

    // Framing error, then the line held low
    nv = n_valid;
    ne = n_err;
    send_frame(6'h15, 1'b0, t0);
    tick(40);
    check("ferr_count", 32'(n_err),        32'(ne + 1));
    check("ferr_cyc",   32'(last_err_cyc), 32'(t0 + 62));
    check("ferr_msg",   32'(msg_out),      32'h3F);
    check("ferr_noval", 32'(n_valid),      32'(nv));
    check("ferr_break", 32'(busy),         32'h1);
    sin = 1'b1;
    tick(6);
    check("ferr_idle", 32'(busy), 32'h0);
    send_frame(6'h2A, 1'b1, t0);
    tick(4);
    check("after_ferr_msg", 32'(last_msg),       32'h2A);
    check("after_ferr_cyc", 32'(last_valid_cyc), 32'(t0 + 62));
    check("after_ferr_cnt", 32'(n_valid),        32'(nv + 1));

    // Reset during data bit 3
    nv = n_valid;
    ne = n_err;
    sin = 1'b0; tick(CPB);           // start
    sin = 1'b1; tick(CPB);           // bit0
    sin = 1'b0; tick(CPB);           // bit1
    sin = 1'b1; tick(CPB);           // bit2
    sin = 1'b1; tick(3);             // part of bit3
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  32'(busy),      32'h0);
    check("mid_rst_msg",   32'(msg_out),   32'h0);
    check("mid_rst_valid", 32'(valid),     32'h0);
    check("mid_rst_ferr",  32'(frame_err), 32'h0);
    sin = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);
    check("mid_rst_noval", 32'(n_valid), 32'(nv));
    check("mid_rst_noerr", 32'(n_err),   32'(ne));
    send_frame(6'h07, 1'b1, t0);
    tick(4);
    check("post_rst_msg", 32'(last_msg),       32'h07);
    check("post_rst_cyc", 32'(last_valid_cyc), 32'(t0 + 62));
    check("post_rst_out", 32'(msg_out),        32'h07);
    check("post_rst_cnt", 32'(n_valid),        32'(nv + 1));

    check("never_both", 32'(n_both), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/message_receiver.md
# message_receiver

Serial receiver for the 6-bit message link. It is the far end of the message processor, which loads a 6-bit `msg` and shifts it out under its controller and counters. This block watches the serial line, finds the start bit and samples each bit mid-period using a 10-bit bit-period counter and a 4-bit bit counter. It then presents the recovered 6-bit message with a one-cycle valid strobe, or flags a framing error.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 4..1023 (fits the 10-bit counter); must be even.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `sin`  in  1: serial line, asynchronous to `clk`; idles high.
- `msg_out`  out  6: last correctly received message.
- `valid`  out  1: one-cycle pulse when `msg_out` has been updated.
- `frame_err`  out  1: one-cycle pulse when the stop bit sampled 0.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Frame on `sin`, in order:
  - start bit = 0;
  - 6 data bits, LSB first;
  - stop bit = 1.
- Synchronizer: two flops, `sin` -> `s1` -> `sin_s`; both flops reset to 1. The FSM uses only `sin_s`.
- Counters:
  - `cnt` is 10 bits and cleared on every state entry.
  - `bitcnt` is 4 bits and counts 0..5 in DATA.
  - `HALF` = `CLKS_PER_BIT`/2.
- States:
  - IDLE:
    - if `sin_s`==0 -> START; `cnt`<=0.
  - START:
    - while `cnt` != `HALF`-1, increment `cnt`;
    - at `cnt`==`HALF`-1, sample `sin_s`:
      - 0 -> DATA, with `cnt`<=0 and `bitcnt`<=0;
      - 1 -> IDLE (glitch rejected; no output activity).
  - DATA:
    - at `cnt`==`CLKS_PER_BIT`-1, shift `sin_s` into the data register at the MSB end (right-shift), so bit 0 ends in `data[0]`;
    - then `cnt`<=0 and `bitcnt`++;
    - after the 6th sample (`bitcnt`==5) -> STOP.
  - STOP: at `cnt`==`CLKS_PER_BIT`-1, sample `sin_s`:
    - 1 -> `msg_out`<=data, `valid`<=1, go IDLE;
    - 0 -> `frame_err`<=1, `msg_out` unchanged, go BREAK.
  - BREAK:
    - wait until `sin_s`==1, then -> IDLE (no re-arm during a held-low line).
- `valid` and `frame_err` are never high together. Each is high for exactly one cycle per frame.
- A new start bit is accepted in the cycle after return to IDLE, so back-to-back frames with a single stop bit are received.

## Timing
- Reset values:
  - `msg_out`=0, `valid`=0, `frame_err`=0, `busy`=0;
  - state IDLE, `cnt`=0, `bitcnt`=0, data=0;
  - `s1`=`sin_s`=1.
- Edge numbering: edge e0 is the first rising edge sampling raw `sin`=0.
  - e1: `sin_s`=0.
  - e2: FSM enters START.
- Sample points:
  - start recheck at e2+`HALF`;
  - data bit k (k=1..6) at e2+`HALF`+k·`CLKS_PER_BIT`;
  - stop at e2+`HALF`+7·`CLKS_PER_BIT`.
- `valid`/`frame_err` are registered on the stop-sample edge and high for the following cycle only.
  - `CLKS_PER_BIT`=16: stop sample / outputs at e122.
  - `CLKS_PER_BIT`=8: stop sample / outputs at e62.
- `busy` is registered and rises on e2.
- `busy` falls on the stop-sample edge for a good frame, or when BREAK exits.
- Reset asserted mid-frame:
  - all outputs and state are cleared immediately (asynchronously);
  - a partial frame is discarded with no `valid` or `frame_err`.
- After reset release, the line must be seen high (`sin_s`=1) before any frame is recognised. This holds automatically because the synchronizer resets to 1.

## Test plan
- Reset: hold `rst` with `sin` toggling -> all outputs 0, `busy`=0. Release with `sin`=1 -> no activity for 100 cycles.
- Single frame, `CLKS_PER_BIT`=8, data 6'b101101 -> `msg_out`=6'h2D and `valid` pulse on e62. `frame_err` stays 0; `busy` falls on e62.
- Back-to-back frames 6'h00 then 6'h3F with a single stop bit each -> two `valid` pulses 64 cycles apart, reading 6'h00 then 6'h3F.
- Glitch: `sin` low for 2 cycles, then high -> START aborts at the recheck. No `valid`/`frame_err`; `busy` returns to 0.
- Framing error: frame 6'h15 with stop bit 0, line then held low 40 cycles -> `frame_err` pulse at e62 and `msg_out` keeps its previous value. The block remains in BREAK until `sin` is high, then receives the next frame 6'h2A correctly.
- Reset mid-frame: assert `rst` during data bit 3 -> immediate clear. A following frame 6'h07 is received with `valid` on e62 relative to its own start bit.
